wb_skid_stage: RTL and testbench
================================

Name: wb_skid_stage

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register.
- Carries a write-back payload (write-enable, mem-to-reg select, ALU result, load data, destination register) between pipeline stages using a valid/ready handshake.
- Adds an optional 2-entry skid buffer so that the upstream ready does not depend combinationally on downstream ready.
- Adds synchronous flush and a saturating back-pressure counter for performance debug.

Parameters:
- DATA_W, 32: width of the ALU-result and read-data fields.
- ADDR_W, 5: width of the destination register address.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready_o; 0 gives a single entry with combinational in_ready_o.
- CNT_W, 16: width of the stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- start_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all held entries.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept a payload.
- in_regwrite_i  in  1  register-file write enable.
- in_memtoreg_i  in  1  select load data for write-back.
- in_aludata_i  in  DATA_W  ALU result.
- in_readdata_i  in  DATA_W  memory load data.
- in_rdaddr_i  in  ADDR_W  destination register.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts the head entry.
- out_regwrite_o  out  1  head write enable; forced to 0 when out_valid_o=0.
- out_memtoreg_o  out  1  head mem-to-reg select.
- out_aludata_o  out  DATA_W  head ALU result.
- out_readdata_o  out  DATA_W  head load data.
- out_rdaddr_o  out  ADDR_W  head destination register.
- occupancy_o  out  2  entries held (0..2).
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating.

Behaviour:
- Handshake definitions: acc = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i. Both are evaluated at the rising edge.
- Reset (start_i=0), asynchronous:
  - State goes to EMPTY.
  - All payload registers, out_* outputs, occupancy_o and stall_cnt_o are 0.
  - in_ready_o=0 while start_i=0.
- States: EMPTY (0 entries), ONE (head only), TWO (head + skid; SKID=1 only).
- SKID=1:
  - in_ready_o = (state!=TWO), a registered function of state only.
  - EMPTY: acc loads head, goes to ONE.
  - ONE, acc & pop: head <= input, stay ONE.
  - ONE, acc & ~pop: skid <= input, go to TWO.
  - ONE, pop & ~acc: go to EMPTY.
  - TWO: pop gives head <= skid, go to ONE. acc is impossible in TWO.
- SKID=0:
  - in_ready_o = (state==EMPTY) | out_ready_i.
  - Same EMPTY/ONE transitions as above; the TWO state is never reached.
- Ordering: entries leave strictly in acceptance order. No entry is duplicated or dropped except by flush.
- Latency: an accepted payload appears at out_* in the cycle after acc when the stage was EMPTY (1 cycle).
- Payload hold: while out_valid_o=1 & ~out_ready_i, every out_* field is stable.
- Drained outputs: when the stage empties, out_regwrite_o=0 and out_memtoreg_o=0 (bubble). Data and address fields keep their last value.
- flush_i=1 at an edge:
  - Next state is EMPTY and occupancy_o=0.
  - Any simultaneous acc is discarded; pop in the same cycle is still reported to downstream.
  - Flush has priority over all other transitions.
  - stall_cnt_o is not cleared by flush.
- stall_cnt_o:
  - +1 per edge where out_valid_o & ~out_ready_i.
  - Holds at 2^CNT_W-1.
  - Cleared only by reset.
- Reset asserted mid-transfer: entries are lost immediately and outputs go to their reset values asynchronously, without waiting for a clock.
- Reset release: with SKID=1, in_ready_o=1 from the first cycle after start_i goes high.

Test Plan:
- Reset → out_valid_o=0, occupancy_o=0, stall_cnt_o=0, all out_*=0, in_ready_o=0. After release in_ready_o=1.
- Streaming: out_ready_i=1, push rd=1..8 with aludata=0x100+rd on consecutive cycles → rd=1..8 appear in order, 1-cycle latency, no gaps, occupancy_o=1 steady.
- Back-pressure (SKID=1): hold out_ready_i=0, push rd=3 then rd=4 → occupancy_o=2 and in_ready_o=0. Push rd=5 is held upstream. stall_cnt_o increments each cycle. Release → out order 3,4,5.
- Flush: with occupancy 2, assert flush_i together with in_valid_i (rd=9) → next cycle occupancy_o=0, out_valid_o=0, out_regwrite_o=0, and rd=9 never appears.
- Saturation: CNT_W=4, stall 20 cycles → stall_cnt_o=15 and holds at 15.
- SKID=0 variant: out_ready_i=0 with one entry held → in_ready_o=0. Set out_ready_i=1 with new input in the same cycle → head replaced, no bubble.

Source files
------------

// File: rtl/wb_skid_stage.sv
// Write-back pipeline stage with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating back-pressure counter.
module wb_skid_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_regwrite_i,
    input  logic              in_memtoreg_i,
    input  logic [DATA_W-1:0] in_aludata_i,
    input  logic [DATA_W-1:0] in_readdata_i,
    input  logic [ADDR_W-1:0] in_rdaddr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_regwrite_o,
    output logic              out_memtoreg_o,
    output logic [DATA_W-1:0] out_aludata_o,
    output logic [DATA_W-1:0] out_readdata_o,
    output logic [ADDR_W-1:0] out_rdaddr_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] aludata;
        logic [DATA_W-1:0] readdata;
        logic [ADDR_W-1:0] rdaddr;
    } ent_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           r_state, w_nxt_state;
    ent_t             r_head, r_skid, w_head_nxt, w_skid_nxt, w_in;
    logic             r_rdy;
    logic             w_acc, w_pop, w_valid;
    logic [CNT_W-1:0] r_stall;

    assign w_in = '{regwrite: in_regwrite_i, memtoreg: in_memtoreg_i,
                    aludata: in_aludata_i, readdata: in_readdata_i,
                    rdaddr: in_rdaddr_i};

    // r_rdy is 0 through reset and the first edge after release; with SKID=1
    // it is the whole ready, otherwise it only gates the combinational path.
    assign w_valid    = (r_state != S_EMPTY);
    assign in_ready_o = (SKID != 0) ? r_rdy
                                    : (r_rdy & ((r_state == S_EMPTY) | out_ready_i));
    assign w_acc      = in_valid_i & in_ready_o;
    assign w_pop      = w_valid & out_ready_i;

    always_comb begin
        w_nxt_state = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_head_nxt  = w_in;
                    w_nxt_state = S_ONE;
                end
            end
            S_ONE: begin
                if (w_acc && w_pop) begin
                    w_head_nxt = w_in;
                end else if (w_acc) begin
                    w_skid_nxt  = w_in;
                    w_nxt_state = S_TWO;
                end else if (w_pop) begin
                    w_nxt_state = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_head_nxt  = r_skid;
                    w_nxt_state = S_ONE;
                end
            end
            default: w_nxt_state = S_EMPTY;
        endcase
        // Flush wins: drop everything and ignore a same-cycle accept.
        if (flush_i) begin
            w_nxt_state = S_EMPTY;
            w_head_nxt  = r_head;
            w_skid_nxt  = r_skid;
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
            r_rdy   <= 1'b0;
            r_stall <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
            r_rdy   <= (w_nxt_state != S_TWO);
            if (w_valid && !out_ready_i && (r_stall != {CNT_W{1'b1}}))
                r_stall <= r_stall + 1'b1;
        end
    end

    // Control bits are masked so a drained stage presents a bubble.
    assign out_valid_o    = w_valid;
    assign out_regwrite_o = r_head.regwrite & w_valid;
    assign out_memtoreg_o = r_head.memtoreg & w_valid;
    assign out_aludata_o  = r_head.aludata;
    assign out_readdata_o = r_head.readdata;
    assign out_rdaddr_o   = r_head.rdaddr;
    assign occupancy_o    = r_state;
    assign stall_cnt_o    = r_stall;

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: a SKID=0 and a SKID=1 instance share stimulus and
// are compared every cycle against a FIFO-level reference model.
module tb_wb_skid_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic          rw;
        logic          m2r;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdat;
        logic [AW-1:0] rd;
    } ent_t;

    logic          clk = 1'b0;
    logic          start, flush, vin, ordy, rw, m2r;
    logic [DW-1:0] alu, rdat;
    logic [AW-1:0] rd;

    logic [1:0]    irdy, ov, orw, om2r;
    logic [DW-1:0] oalu [2];
    logic [DW-1:0] ordat[2];
    logic [AW-1:0] ord  [2];
    logic [1:0]    occ  [2];
    logic [CW-1:0] stl  [2];

    int checks = 0;
    int errors = 0;

    // reference model: per instance an ordered list of held entries
    ent_t mq   [2][2];
    int   mcnt [2];
    ent_t mlast[2];
    int   mstall[2];
    bit   alive;

    always #5 clk = ~clk;

    wb_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID(0), .CNT_W(CW)) u_noskid (
        .clk_i(clk), .start_i(start), .flush_i(flush),
        .in_valid_i(vin), .in_ready_o(irdy[0]),
        .in_regwrite_i(rw), .in_memtoreg_i(m2r), .in_aludata_i(alu),
        .in_readdata_i(rdat), .in_rdaddr_i(rd),
        .out_valid_o(ov[0]), .out_ready_i(ordy),
        .out_regwrite_o(orw[0]), .out_memtoreg_o(om2r[0]),
        .out_aludata_o(oalu[0]), .out_readdata_o(ordat[0]), .out_rdaddr_o(ord[0]),
        .occupancy_o(occ[0]), .stall_cnt_o(stl[0])
    );

    wb_skid_stage #(.DATA_W(DW), .ADDR_W(AW), .SKID(1), .CNT_W(CW)) u_skid (
        .clk_i(clk), .start_i(start), .flush_i(flush),
        .in_valid_i(vin), .in_ready_o(irdy[1]),
        .in_regwrite_i(rw), .in_memtoreg_i(m2r), .in_aludata_i(alu),
        .in_readdata_i(rdat), .in_rdaddr_i(rd),
        .out_valid_o(ov[1]), .out_ready_i(ordy),
        .out_regwrite_o(orw[1]), .out_memtoreg_o(om2r[1]),
        .out_aludata_o(oalu[1]), .out_readdata_o(ordat[1]), .out_rdaddr_o(ord[1]),
        .occupancy_o(occ[1]), .stall_cnt_o(stl[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // SKID=1 (k=1): ready unless two entries are held.
    // SKID=0 (k=0): ready when empty or the head leaves this cycle.
    function automatic bit mrdy(input int k);
        if (!alive) return 1'b0;
        if (k == 1) return mcnt[1] != 2;
        return (mcnt[0] == 0) || ordy;
    endfunction

    always @(posedge clk or negedge start) begin
        if (!start) begin
            alive = 1'b0;
            for (int k = 0; k < 2; k++) begin
                mcnt[k]   = 0;
                mstall[k] = 0;
                mlast[k]  = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit a, p;
                a = vin && mrdy(k);
                p = (mcnt[k] > 0) && ordy;
                if (mcnt[k] > 0 && !ordy && mstall[k] < SAT) mstall[k]++;
                if (flush) begin
                    mcnt[k] = 0;
                end else begin
                    if (p) begin
                        mq[k][0] = mq[k][1];
                        mcnt[k]--;
                    end
                    if (a) begin
                        mq[k][mcnt[k]] = '{rw: rw, m2r: m2r, alu: alu, rdat: rdat, rd: rd};
                        mcnt[k]++;
                    end
                end
                if (mcnt[k] > 0) mlast[k] = mq[k][0];
            end
            alive = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit   v;
            ent_t h;
            v = mcnt[k] > 0;
            h = v ? mq[k][0] : mlast[k];
            chk($sformatf("d%0d_in_ready", k), 64'(irdy[k]), 64'(mrdy(k)));
            chk($sformatf("d%0d_valid", k),    64'(ov[k]),   64'(v));
            chk($sformatf("d%0d_occ", k),      64'(occ[k]),  64'(mcnt[k]));
            chk($sformatf("d%0d_stall", k),    64'(stl[k]),  64'(mstall[k]));
            chk($sformatf("d%0d_regwrite", k), 64'(orw[k]),  64'(v & h.rw));
            chk($sformatf("d%0d_memtoreg", k), 64'(om2r[k]), 64'(v & h.m2r));
            chk($sformatf("d%0d_aludata", k),  64'(oalu[k]), 64'(h.alu));
            chk($sformatf("d%0d_readdata", k), 64'(ordat[k]), 64'(h.rdat));
            chk($sformatf("d%0d_rdaddr", k),   64'(ord[k]),  64'(h.rd));
        end
    end

    // Apply one cycle of inputs, then step past the next rising edge.
    task automatic drive(input logic v, input logic [AW-1:0] r, input logic ordy_v, input logic fl);
        vin   = v;
        rd    = r;
        alu   = 32'h100 + 32'(r);
        rdat  = $urandom;
        rw    = 1'($urandom_range(0, 1));
        m2r   = 1'($urandom_range(0, 1));
        ordy  = ordy_v;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        start = 1'b0; flush = 1'b0; vin = 1'b0; ordy = 1'b0;
        rw = 1'b0; m2r = 1'b0; alu = '0; rdat = '0; rd = '0;
        repeat (2) drive(1'b0, 5'd0, 1'b0, 1'b0);
        start = 1'b1;
        repeat (2) drive(1'b0, 5'd0, 1'b1, 1'b0);

        // streaming
        for (int i = 1; i <= 8; i++) drive(1'b1, AW'(i), 1'b1, 1'b0);
        repeat (2) drive(1'b0, 5'd0, 1'b1, 1'b0);

        // back-pressure then release
        drive(1'b1, 5'd3, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 5'd5, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 5'd5, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 5'd0, 1'b1, 1'b0);

        // flush with a simultaneous push
        drive(1'b1, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 5'd9, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 5'd0, 1'b1, 1'b0);

        // stall counter saturation
        drive(1'b1, 5'd10, 1'b0, 1'b0);
        repeat (20) drive(1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 5'd0, 1'b1, 1'b0);

        // asynchronous reset with entries held
        drive(1'b1, 5'd11, 1'b0, 1'b0);
        drive(1'b1, 5'd12, 1'b0, 1'b0);
        #2 start = 1'b0;
        #1;
        chk("async_valid", 64'(ov), 64'd0);
        chk("async_ready", 64'(irdy), 64'd0);
        chk("async_occ", 64'({occ[1], occ[0]}), 64'd0);
        chk("async_stall", 64'({stl[1], stl[0]}), 64'd0);
        chk("async_aludata", {oalu[1], oalu[0]}, 64'd0);
        chk("async_rdaddr", 64'({ord[1], ord[0]}), 64'd0);
        @(posedge clk);
        #1 start = 1'b1;
        drive(1'b0, 5'd0, 1'b1, 1'b0);

        // randomized traffic with alternating back-pressure phases
        for (int i = 0; i < 600; i++) begin
            logic o;
            o = ((i % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)), o,
                  $urandom_range(0, 39) == 0);
        end
        drive(1'b0, 5'd0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
